// File: rtl/exec_pkg.sv
// -----------------------------------------------------------------------------
// exec_pkg
//   Shared definitions for the execute stage. It holds the aluOp encodings, the
//   state type of the iterative multiplier and the default multiplier
//   iteration count.
// -----------------------------------------------------------------------------
package exec_pkg;

    // The multiplier produces one product bit per cycle, so this count must
    // match the datapath width.
    localparam int MUL_CYCLES = 32;

    // aluOp encodings
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_MUL = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    // True for the operations whose signed overflow is reported on the
    // overflow flag.
    function automatic logic is_add_sub(input logic [2:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

endpackage : exec_pkg

// File: rtl/iter_multiplier.sv
// -----------------------------------------------------------------------------
// iter_multiplier
//   Radix-2 shift-add multiplier. It returns the low WIDTH bits of a*b.
//   A start in IDLE loads the operands. BUSY then runs one shift-add step per
//   cycle for MUL_CYCLES cycles. DONE lasts one cycle and presents the finished
//   product. The FSM always returns to IDLE after DONE, so a request that is
//   still held on the inputs is not launched again from DONE.
//
// Ports
//   clk      in   clock
//   reset    in   synchronous, active-high reset (discards any partial product)
//   start    in   request a multiply (acted on only in IDLE)
//   a, b     in   operands, sampled only on launch
//   busy     out  FSM is in BUSY
//   done     out  FSM is in DONE; product is valid during this cycle
//   product  out  low WIDTH bits of a*b
// -----------------------------------------------------------------------------
module iter_multiplier
    import exec_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = exec_pkg::MUL_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MUL_CYCLES - 1);

    mul_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_mcand;   // multiplicand, shifted left each step
    logic [WIDTH-1:0] r_mplier;  // multiplier, shifted right each step
    logic [WIDTH-1:0] r_acc;     // running partial product

    // NOTE: sequential state uses non-blocking assignments only. Every flop
    //       then samples values from before the edge, so the order of the
    //       statements inside the block does not matter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_mcand  <= a;
                        r_mplier <= b;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_state  <= BUSY;
                    end
                end
                BUSY: begin
                    // The low multiplier bit decides whether the shifted
                    // multiplicand is added in. Bits shifted out past WIDTH
                    // cannot affect the low half of the product.
                    if (r_mplier[0]) begin
                        r_acc <= r_acc + r_mcand;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_CNT) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy    = (r_state == BUSY);
    assign done    = (r_state == DONE);
    assign product = r_acc;

endmodule : iter_multiplier

// File: rtl/execute_stage.sv
// -----------------------------------------------------------------------------
// execute_stage
//   EX stage of the 5-stage pipeline. It selects operand B, evaluates the
//   single-cycle ALU operations, runs MUL on the iterative multiplier, and
//   loads the EX/MEM pipeline register. While a multiply is in flight, stall
//   freezes ID/EX and EX/MEM takes bubbles. In the DONE cycle stall drops and
//   EX/MEM captures the product together with the controls that ID/EX has held.
//
// Ports
//   clk, reset                         clock, synchronous active-high reset
//   valid_ex                           ID/EX holds a real instruction
//   aluOp, ALUSrc                      operation select, operand-B select
//   rsData, rtData, imm                operand A, Rt value / store data, immediate
//   MemWrite_ex, MemToReg_ex,
//   RegWrite_ex, Rt_ex, Rd_ex          controls and specifiers from ID/EX
//   memAddr, storedRt2                 registered result and store data
//   Rt_mem, Rd_mem                     registered specifiers
//   MemWrite, MemToReg, RegWrite_mem   registered controls
//   zero, overflow, negative           registered flags of memAddr
//   stall                              combinational upstream hold
// -----------------------------------------------------------------------------
module execute_stage
    import exec_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int REGW       = 5,
    parameter int MUL_CYCLES = exec_pkg::MUL_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_ex,
    input  logic [2:0]       aluOp,
    input  logic             ALUSrc,
    input  logic [WIDTH-1:0] rsData,
    input  logic [WIDTH-1:0] rtData,
    input  logic [WIDTH-1:0] imm,
    input  logic             MemWrite_ex,
    input  logic             MemToReg_ex,
    input  logic             RegWrite_ex,
    input  logic [REGW-1:0]  Rt_ex,
    input  logic [REGW-1:0]  Rd_ex,
    output logic [WIDTH-1:0] memAddr,
    output logic [WIDTH-1:0] storedRt2,
    output logic [REGW-1:0]  Rt_mem,
    output logic [REGW-1:0]  Rd_mem,
    output logic             MemWrite,
    output logic             MemToReg,
    output logic             RegWrite_mem,
    output logic             zero,
    output logic             overflow,
    output logic             negative,
    output logic             stall
);

    localparam int SHW = $clog2(WIDTH);

    // ------------------------------------------------------------------
    // Operand select and single-cycle ALU
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_op_b;
    logic [WIDTH-1:0] w_alu_result;
    logic             w_alu_overflow;

    assign w_op_b = ALUSrc ? imm : rtData;

    // NOTE: every output of this block gets a default first, so no path can
    //       leave a value unassigned and infer a latch.
    always_comb begin
        w_alu_result   = '0;
        w_alu_overflow = 1'b0;
        case (aluOp)
            ALU_ADD: begin
                w_alu_result = rsData + w_op_b;
                // Overflow happens when both operands have the same sign and
                // the sum has the other sign.
                w_alu_overflow = (rsData[WIDTH-1] == w_op_b[WIDTH-1]) &&
                                 (w_alu_result[WIDTH-1] != rsData[WIDTH-1]);
            end
            ALU_SUB: begin
                w_alu_result = rsData - w_op_b;
                // Overflow happens when the operands have opposite signs and
                // the difference does not keep the sign of A.
                w_alu_overflow = (rsData[WIDTH-1] != w_op_b[WIDTH-1]) &&
                                 (w_alu_result[WIDTH-1] != rsData[WIDTH-1]);
            end
            ALU_AND: w_alu_result = rsData & w_op_b;
            ALU_OR:  w_alu_result = rsData | w_op_b;
            ALU_XOR: w_alu_result = rsData ^ w_op_b;
            ALU_SLT: w_alu_result = {{(WIDTH-1){1'b0}},
                                     ($signed(rsData) < $signed(w_op_b))};
            ALU_SLL: w_alu_result = rsData << w_op_b[SHW-1:0];
            default: begin
                // MUL: the result comes from the multiplier.
                w_alu_result   = '0;
                w_alu_overflow = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Iterative multiplier and stall generation
    // ------------------------------------------------------------------
    logic             w_mul_req;
    logic             w_mul_busy;
    logic             w_mul_done;
    logic             w_mul_idle;
    logic [WIDTH-1:0] w_mul_product;

    assign w_mul_req = valid_ex && (aluOp == ALU_MUL);

    iter_multiplier #(
        .WIDTH      (WIDTH),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (w_mul_req),
        .a       (rsData),
        .b       (w_op_b),
        .busy    (w_mul_busy),
        .done    (w_mul_done),
        .product (w_mul_product)
    );

    assign w_mul_idle = !w_mul_busy && !w_mul_done;

    // Stall covers the launch cycle in IDLE and every BUSY cycle. It is low in
    // DONE, which lets EX/MEM take the product and lets ID/EX advance. Reset
    // forces it low so upstream is never held during reset.
    assign stall = !reset && (w_mul_busy || (w_mul_req && w_mul_idle));

    // ------------------------------------------------------------------
    // Result select and EX/MEM pipeline register
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_result;
    logic             w_overflow;
    logic             w_load_bubble;

    // A valid MUL reaches EX/MEM only when stall is low, which is the DONE
    // cycle, so the product register is final here.
    assign w_result      = (aluOp == ALU_MUL) ? w_mul_product : w_alu_result;
    assign w_overflow    = is_add_sub(aluOp) && w_alu_overflow;
    assign w_load_bubble = stall || !valid_ex;

    logic [WIDTH-1:0] r_mem_addr;
    logic [WIDTH-1:0] r_stored_rt;
    logic [REGW-1:0]  r_rt_mem;
    logic [REGW-1:0]  r_rd_mem;
    logic             r_mem_write;
    logic             r_mem_to_reg;
    logic             r_reg_write;
    logic             r_zero;
    logic             r_overflow;
    logic             r_negative;

    always_ff @(posedge clk) begin
        if (reset || w_load_bubble) begin
            r_mem_addr   <= '0;
            r_stored_rt  <= '0;
            r_rt_mem     <= '0;
            r_rd_mem     <= '0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_reg_write  <= 1'b0;
            r_zero       <= 1'b0;
            r_overflow   <= 1'b0;
            r_negative   <= 1'b0;
        end else begin
            r_mem_addr   <= w_result;
            r_stored_rt  <= rtData;    // store data is always Rt, never imm
            r_rt_mem     <= Rt_ex;
            r_rd_mem     <= Rd_ex;
            r_mem_write  <= MemWrite_ex;
            r_mem_to_reg <= MemToReg_ex;
            r_reg_write  <= RegWrite_ex;
            r_zero       <= (w_result == '0);
            r_overflow   <= w_overflow;
            r_negative   <= w_result[WIDTH-1];
        end
    end

    assign memAddr      = r_mem_addr;
    assign storedRt2    = r_stored_rt;
    assign Rt_mem       = r_rt_mem;
    assign Rd_mem       = r_rd_mem;
    assign MemWrite     = r_mem_write;
    assign MemToReg     = r_mem_to_reg;
    assign RegWrite_mem = r_reg_write;
    assign zero         = r_zero;
    assign overflow     = r_overflow;
    assign negative     = r_negative;

endmodule : execute_stage

// File: tb/tb_execute_stage.sv
// -----------------------------------------------------------------------------
// tb_execute_stage
//   Directed bench for execute_stage. Every cycle pushes the EX/MEM contents
//   expected at the closing edge into a scoreboard. Bubbles are pushed during
//   stall and reset cycles, and a reference-model result is pushed for a real
//   instruction. After the edge the entry is popped and compared field by
//   field. Stall is compared in the middle of every cycle.
// -----------------------------------------------------------------------------
module tb_execute_stage;
    import exec_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_ex;
    logic [2:0]  aluOp;
    logic        ALUSrc;
    logic [31:0] rsData, rtData, imm;
    logic        MemWrite_ex, MemToReg_ex, RegWrite_ex;
    logic [4:0]  Rt_ex, Rd_ex;
    logic [31:0] memAddr, storedRt2;
    logic [4:0]  Rt_mem, Rd_mem;
    logic        MemWrite, MemToReg, RegWrite_mem;
    logic        zero, overflow, negative, stall;

    execute_stage dut (
        .clk          (clk),
        .reset        (reset),
        .valid_ex     (valid_ex),
        .aluOp        (aluOp),
        .ALUSrc       (ALUSrc),
        .rsData       (rsData),
        .rtData       (rtData),
        .imm          (imm),
        .MemWrite_ex  (MemWrite_ex),
        .MemToReg_ex  (MemToReg_ex),
        .RegWrite_ex  (RegWrite_ex),
        .Rt_ex        (Rt_ex),
        .Rd_ex        (Rd_ex),
        .memAddr      (memAddr),
        .storedRt2    (storedRt2),
        .Rt_mem       (Rt_mem),
        .Rd_mem       (Rd_mem),
        .MemWrite     (MemWrite),
        .MemToReg     (MemToReg),
        .RegWrite_mem (RegWrite_mem),
        .zero         (zero),
        .overflow     (overflow),
        .negative     (negative),
        .stall        (stall)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] srt;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        mw;
        logic        m2r;
        logic        rw;
        logic        z;
        logic        ov;
        logic        neg;
    } exp_t;

    localparam exp_t BUBBLE = '0;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model, written directly from the operation definitions.
    function automatic exp_t model(input logic [2:0] op, input logic src,
                                   input logic [31:0] rs, input logic [31:0] rt,
                                   input logic [31:0] im, input logic mw,
                                   input logic m2r, input logic rw,
                                   input logic [4:0] rtsp, input logic [4:0] rdsp);
        exp_t        e;
        logic [31:0] b;
        longint      s;
        e = '0;
        b = src ? im : rt;
        s = 0;
        case (op)
            ALU_ADD: begin
                e.addr = rs + b;
                s = longint'($signed(rs)) + longint'($signed(b));
                e.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            ALU_SUB: begin
                e.addr = rs - b;
                s = longint'($signed(rs)) - longint'($signed(b));
                e.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            ALU_AND: e.addr = rs & b;
            ALU_OR:  e.addr = rs | b;
            ALU_XOR: e.addr = rs ^ b;
            ALU_SLT: e.addr = ($signed(rs) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLL: e.addr = rs << b[4:0];
            default: e.addr = rs * b;
        endcase
        e.srt = rt;
        e.rt  = rtsp;
        e.rd  = rdsp;
        e.mw  = mw;
        e.m2r = m2r;
        e.rw  = rw;
        e.z   = (e.addr == 32'd0);
        e.neg = e.addr[31];
        return e;
    endfunction

    task automatic drive(input logic v, input logic [2:0] op, input logic src,
                         input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] im, input logic mw, input logic m2r,
                         input logic rw, input logic [4:0] rtsp, input logic [4:0] rdsp);
        valid_ex    = v;
        aluOp       = op;
        ALUSrc      = src;
        rsData      = rs;
        rtData      = rt;
        imm         = im;
        MemWrite_ex = mw;
        MemToReg_ex = m2r;
        RegWrite_ex = rw;
        Rt_ex       = rtsp;
        Rd_ex       = rdsp;
    endtask

    // One clock cycle: compare stall mid-cycle, cross the edge, then pop and
    // compare the EX/MEM contents.
    task automatic tick(input logic exp_stall, input string tag);
        exp_t e;
        #1;
        chk({tag, ".stall"}, {31'd0, stall}, {31'd0, exp_stall});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, ".scoreboard_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, ".memAddr"},   memAddr,               e.addr);
            chk({tag, ".storedRt2"}, storedRt2,             e.srt);
            chk({tag, ".Rt_mem"},    {27'd0, Rt_mem},       {27'd0, e.rt});
            chk({tag, ".Rd_mem"},    {27'd0, Rd_mem},       {27'd0, e.rd});
            chk({tag, ".MemWrite"},  {31'd0, MemWrite},     {31'd0, e.mw});
            chk({tag, ".MemToReg"},  {31'd0, MemToReg},     {31'd0, e.m2r});
            chk({tag, ".RegWrite"},  {31'd0, RegWrite_mem}, {31'd0, e.rw});
            chk({tag, ".zero"},      {31'd0, zero},         {31'd0, e.z});
            chk({tag, ".overflow"},  {31'd0, overflow},     {31'd0, e.ov});
            chk({tag, ".negative"},  {31'd0, negative},     {31'd0, e.neg});
        end
    endtask

    task automatic single(input string tag, input logic [2:0] op, input logic src,
                          input logic [31:0] rs, input logic [31:0] rt,
                          input logic [31:0] im, input logic mw, input logic m2r,
                          input logic rw, input logic [4:0] rtsp, input logic [4:0] rdsp);
        drive(1'b1, op, src, rs, rt, im, mw, m2r, rw, rtsp, rdsp);
        sb.push_back(model(op, src, rs, rt, im, mw, m2r, rw, rtsp, rdsp));
        tick(1'b0, tag);
    endtask

    // MUL: 33 stalled cycles with bubbles, then the DONE cycle captures the
    // product. With scramble set, operand inputs are disturbed during BUSY and
    // restored for DONE.
    task automatic mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit scramble);
        drive(1'b1, ALU_MUL, 1'b0, a, b, 32'd0, 1'b0, 1'b0, 1'b1, 5'd2, rd);
        for (int i = 0; i < 33; i++) begin
            sb.push_back(BUBBLE);
            tick(1'b1, {tag, ".busy"});
            if (scramble) begin
                rsData = $urandom;
                rtData = $urandom;
            end
        end
        rsData = a;
        rtData = b;
        sb.push_back(model(ALU_MUL, 1'b0, a, b, 32'd0, 1'b0, 1'b0, 1'b1, 5'd2, rd));
        tick(1'b0, {tag, ".done"});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        drive(1'b0, ALU_ADD, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
        @(posedge clk);
        #1;
        sb.push_back(BUBBLE);
        tick(1'b0, "reset");
        reset = 1'b0;

        // Single-cycle operations
        single("add_ovf", ALU_ADD, 1'b0, 32'h7FFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd5);
        single("store",   ALU_ADD, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 5'd7, 5'd0);
        single("sub_zero", ALU_SUB, 1'b0, 32'd5, 32'd5, 32'd0, 1'b0, 1'b0, 1'b1, 5'd1, 5'd3);
        single("sub_ovf", ALU_SUB, 1'b0, 32'h8000_0000, 32'd1, 32'd0, 1'b0, 1'b0, 1'b1, 5'd1, 5'd4);
        single("slt",     ALU_SLT, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, 1'b1, 5'd2, 5'd6);
        single("sll",     ALU_SLL, 1'b1, 32'd3, 32'd9, 32'd4, 1'b0, 1'b0, 1'b1, 5'd9, 5'd10);
        single("load",    ALU_ADD, 1'b1, 32'h0000_2000, 32'h1234_5678, 32'd8, 1'b0, 1'b1, 1'b1, 5'd11, 5'd0);
        for (int i = 0; i < 16; i++) begin
            single("rand", 3'($urandom_range(0, 6)), 1'($urandom), $urandom, $urandom, $urandom,
                   1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), 5'($urandom));
        end

        // A MUL encoding on a bubble must not start the multiplier.
        drive(1'b0, ALU_MUL, 1'b0, 32'd7, 32'd9, 32'd0, 1'b1, 1'b1, 1'b1, 5'd3, 5'd3);
        sb.push_back(BUBBLE);
        tick(1'b0, "bubble_mul");

        // Multiplies
        mul("mul_12345", 32'd12345, 32'd6789, 5'd9, 1'b1);
        mul("mul_neg1x2", 32'hFFFF_FFFF, 32'd2, 5'd12, 1'b0);
        mul("b2b_first", 32'd3, 32'd4, 5'd13, 1'b0);
        mul("b2b_second", 32'd5, 32'd6, 5'd14, 1'b0);
        single("after_mul", ALU_OR, 1'b0, 32'hF0F0_0000, 32'h0000_0F0F, 32'd0, 1'b0, 1'b0, 1'b1, 5'd1, 5'd15);

        // Reset while BUSY with the iteration counter at 10
        drive(1'b1, ALU_MUL, 1'b0, 32'd1000, 32'd1000, 32'd0, 1'b0, 1'b0, 1'b1, 5'd2, 5'd16);
        for (int i = 0; i < 11; i++) begin
            sb.push_back(BUBBLE);
            tick(1'b1, "mul_abort");
        end
        reset = 1'b1;
        drive(1'b0, ALU_ADD, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
        sb.push_back(BUBBLE);
        tick(1'b0, "mid_reset");
        reset = 1'b0;
        single("post_reset_add", ALU_ADD, 1'b0, 32'd2, 32'd3, 32'd0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd17);
        mul("post_reset_mul", 32'd7, 32'd8, 5'd18, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_execute_stage
